// File: rtl/peak_search_pkg.sv
// Shared widths and scan FSM encoding for the time-of-flight peak search.
// Kept alongside the SiFH parameter header so both sides agree on the widths.
package peak_search_pkg;

    localparam int NB = 8;   // bin-index width, 2^NB bins per histogram
    localparam int CW = 16;  // bin count width
    localparam int PW = 4;   // pixel-index width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scanState;

endpackage

// File: rtl/peak_search_compare.sv
// Registered running max / argmax. Strictly-greater update, so on a tie the
// lowest index seen wins. Also exposes the value that includes the current word.
module peak_compare #(
    parameter int CW = 16,
    parameter int NB = 8
) (
    input  logic          clk,
    input  logic          res,
    input  logic          clear,
    input  logic          valid,
    input  logic [NB-1:0] idx,
    input  logic [CW-1:0] data,
    output logic [CW-1:0] nextVal,
    output logic [NB-1:0] nextIdx
);

    logic [CW-1:0] maxVal;
    logic [NB-1:0] maxIdx;
    logic          take;

    always_comb begin
        take    = valid && (data > maxVal);
        nextVal = take ? data : maxVal;
        nextIdx = take ? idx  : maxIdx;
    end

    always_ff @(posedge clk) begin
        if (!res || clear) begin
            maxVal <= '0;
            maxIdx <= '0;
        end else begin
            maxVal <= nextVal;
            maxIdx <= nextIdx;
        end
    end

endmodule

// File: rtl/peak_search.sv
// Scans one pixel's histogram, reports the highest-count bin and clears every
// bin one cycle after reading it so the histogram is empty for the next frame.
module peak_search
    import peak_search_pkg::*;
#(
    parameter int NB = peak_search_pkg::NB,
    parameter int CW = peak_search_pkg::CW,
    parameter int PW = peak_search_pkg::PW
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic [PW-1:0]    pix_in,
    input  logic [CW-1:0]    th_min,
    output logic             busy,
    output logic             rd_en,
    output logic [PW+NB-1:0] rd_addr,
    input  logic [CW-1:0]    rd_data,
    output logic             wr_en,
    output logic [PW+NB-1:0] wr_addr,
    output logic [NB-1:0]    peakCH,
    output logic [CW-1:0]    peakCount,
    output logic [PW-1:0]    peakPix,
    output logic             peakValid,
    output logic             peakDone,
    output logic [1:0]       dbgState
);

    localparam logic [NB:0] LAST_BIN = (NB+1)'((2 ** NB) - 1);
    localparam logic [NB:0] BIN_ONE  = (NB+1)'(1);

    scanState           state, stateNxt;
    logic [PW-1:0]      pix;
    logic [CW-1:0]      thMin;
    logic [NB:0]        bin;
    logic               rdEnQ;
    logic [PW+NB-1:0]   rdAddrQ;
    logic               accept;
    logic [CW-1:0]      nextVal;
    logic [NB-1:0]      nextIdx;

    assign accept = (state == IDLE) && start;

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:    if (start) stateNxt = READ;
            READ:    if (bin == LAST_BIN) stateNxt = DRAIN;
            DRAIN:   stateNxt = DONE;
            DONE:    stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    // Read address is forced to zero outside READ so idle outputs stay quiet.
    always_comb begin
        rd_en    = (state == READ);
        rd_addr  = rd_en ? {pix, bin[NB-1:0]} : '0;
        busy     = (state != IDLE);
        wr_en    = rdEnQ;
        wr_addr  = rdAddrQ;
        dbgState = state;
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state     <= IDLE;
            pix       <= '0;
            thMin     <= '0;
            bin       <= '0;
            rdEnQ     <= 1'b0;
            rdAddrQ   <= '0;
            peakCH    <= '0;
            peakCount <= '0;
            peakPix   <= '0;
            peakValid <= 1'b0;
            peakDone  <= 1'b0;
        end else begin
            state    <= stateNxt;
            rdEnQ    <= rd_en;
            rdAddrQ  <= rd_addr;
            peakDone <= 1'b0;
            if (accept) begin
                pix   <= pix_in;
                thMin <= th_min;
                bin   <= '0;
            end
            if (rd_en) bin <= bin + BIN_ONE;
            // The last word is compared in DRAIN, so capture the combined result here.
            if (state == DRAIN) begin
                peakCH    <= nextIdx;
                peakCount <= nextVal;
                peakPix   <= pix;
                peakValid <= (nextVal >= thMin);
                peakDone  <= 1'b1;
            end
        end
    end

    peak_compare #(.CW(CW), .NB(NB)) u_compare (
        .clk     (clk),
        .res     (res),
        .clear   (accept),
        .valid   (rdEnQ),
        .idx     (rdAddrQ[NB-1:0]),
        .data    (rd_data),
        .nextVal (nextVal),
        .nextIdx (nextIdx)
    );

endmodule

// File: tb/tb_peak_search.sv
// Directed bench for peak_search with a behavioural 1-cycle-latency BRAM
// that also honours the clear port.
module tb_peak_search;

    localparam int NB = 8;
    localparam int CW = 16;
    localparam int PW = 4;
    localparam int NBINS = 2 ** NB;

    logic             clk = 1'b0;
    logic             res = 1'b0;
    logic             start = 1'b0;
    logic [PW-1:0]    pix_in = '0;
    logic [CW-1:0]    th_min = '0;
    logic             busy, rd_en, wr_en, peakValid, peakDone;
    logic [PW+NB-1:0] rd_addr, wr_addr;
    logic [CW-1:0]    rd_data, peakCount;
    logic [NB-1:0]    peakCH;
    logic [PW-1:0]    peakPix;
    logic [1:0]       dbgState;

    logic             tbWe = 1'b0;
    logic [PW+NB-1:0] tbAddr = '0;
    logic [CW-1:0]    tbData = '0;
    logic [CW-1:0]    mem [2 ** (PW+NB)];
    logic [CW-1:0]    hist [NBINS];
    logic [PW-1:0]    curPix = '0;
    int               rdCount = 0;
    int               offPix = 0;
    int               doneCount = 0;
    int               total = 0;
    int               bad = 0;
    logic [NB+CW+PW:0] exp_q[$];

    always #5 clk = ~clk;

    peak_search dut (
        .clk(clk), .res(res), .start(start), .pix_in(pix_in), .th_min(th_min),
        .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .peakCH(peakCH), .peakCount(peakCount),
        .peakPix(peakPix), .peakValid(peakValid), .peakDone(peakDone),
        .dbgState(dbgState)
    );

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= '0;
        if (tbWe) mem[tbAddr] <= tbData;
    end

    always @(posedge clk) begin
        if (rd_en) begin
            rdCount <= rdCount + 1;
            if (rd_addr[PW+NB-1:NB] != curPix) offPix <= offPix + 1;
        end
        if (peakDone) doneCount <= doneCount + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic loadHist(input int p);
        for (int i = 0; i < NBINS; i++) begin
            @(negedge clk);
            tbWe   = 1'b1;
            tbAddr = {PW'(p), NB'(i)};
            tbData = hist[i];
        end
        @(negedge clk);
        tbWe = 1'b0;
    endtask

    task automatic fillHist(input int v);
        for (int i = 0; i < NBINS; i++) hist[i] = CW'(v);
    endtask

    // Returns at the negedge just after the accepting clock edge.
    task automatic startScan(input int p, input int th);
        @(negedge clk);
        start  = 1'b1;
        pix_in = PW'(p);
        th_min = CW'(th);
        curPix = PW'(p);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int base, output int lat);
        lat = base;
        while (!peakDone && lat < 400) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pushExp(input int ch, input int cnt, input int p, input int v);
        exp_q.push_back({NB'(ch), CW'(cnt), PW'(p), 1'(v)});
    endtask

    task automatic checkResult(input string tag);
        logic [NB+CW+PW:0] e;
        e = exp_q.pop_front();
        check({tag, ".done"},  32'(peakDone), 32'd1);
        check({tag, ".ch"},    32'(peakCH), 32'(e[NB+CW+PW:CW+PW+1]));
        check({tag, ".count"}, 32'(peakCount), 32'(e[CW+PW:PW+1]));
        check({tag, ".pix"},   32'(peakPix), 32'(e[PW:1]));
        check({tag, ".valid"}, 32'(peakValid), 32'(e[0]));
        @(negedge clk);
        check({tag, ".pulse"}, 32'(peakDone), 32'd0);
        check({tag, ".idle"},  32'(busy), 32'd0);
    endtask

    function automatic int nonZeroBins(input int p);
        int n = 0;
        for (int i = 0; i < NBINS; i++)
            if (mem[{PW'(p), NB'(i)}] != '0) n++;
        return n;
    endfunction

    initial begin
        int lat;
        int r0, o0, d0, n;

        // reset state
        repeat (3) @(negedge clk);
        check("rst.busy", 32'(busy), 0);
        check("rst.rd_en", 32'(rd_en), 0);
        check("rst.wr_en", 32'(wr_en), 0);
        check("rst.rd_addr", 32'(rd_addr), 0);
        check("rst.wr_addr", 32'(wr_addr), 0);
        check("rst.peakDone", 32'(peakDone), 0);
        check("rst.peakCount", 32'(peakCount), 0);
        res = 1'b1;

        // single dominant peak, pipeline timing and clearing
        for (int i = 0; i < NBINS; i++) hist[i] = CW'(i % 21);
        hist[37] = 16'd500;
        loadHist(3);
        pushExp(37, 500, 3, 1);
        startScan(3, 100);
        check("t1.busy0", 32'(busy), 1);
        check("t1.rd_en0", 32'(rd_en), 1);
        check("t1.rd_addr0", 32'(rd_addr), 32'h300);
        check("t1.wr_en0", 32'(wr_en), 0);
        @(negedge clk);
        check("t1.wr_en1", 32'(wr_en), 1);
        check("t1.wr_addr1", 32'(wr_addr), 32'h300);
        check("t1.rd_addr1", 32'(rd_addr), 32'h301);
        waitDone(2, lat);
        check("t1.latency", 32'(lat), 258);
        checkResult("t1");
        check("t1.cleared", 32'(nonZeroBins(3)), 0);

        // tie keeps lowest bin; th_min equal to peak is valid
        fillHist(5);
        hist[10] = 16'd900;
        hist[200] = 16'd900;
        loadHist(1);
        pushExp(10, 900, 1, 1);
        startScan(1, 900);
        waitDone(1, lat);
        check("t2.latency", 32'(lat), 258);
        checkResult("t2");

        // all-zero histogram
        fillHist(0);
        loadHist(7);
        pushExp(0, 0, 7, 0);
        startScan(7, 1);
        waitDone(1, lat);
        checkResult("t3");

        // only the last bin set; the next pixel holds bigger data that must not be read
        fillHist(1000);
        loadHist(10);
        fillHist(0);
        hist[255] = 16'd7;
        loadHist(9);
        r0 = rdCount;
        o0 = offPix;
        pushExp(255, 7, 9, 1);
        startScan(9, 7);
        waitDone(1, lat);
        checkResult("t4");
        check("t4.reads", 32'(rdCount - r0), 256);
        check("t4.offPix", 32'(offPix - o0), 0);
        check("t4.nextPix", 32'(nonZeroBins(10)), 256);

        // start during a scan is ignored
        fillHist(3);
        hist[128] = 16'd300;
        loadHist(2);
        d0 = doneCount;
        pushExp(128, 300, 2, 0);
        startScan(2, 500);
        repeat (49) @(negedge clk);
        start = 1'b1;
        pix_in = 4'd12;
        th_min = 16'd0;
        @(negedge clk);
        start = 1'b0;
        check("t5.busy", 32'(busy), 1);
        waitDone(51, lat);
        check("t5.latency", 32'(lat), 258);
        checkResult("t5");
        repeat (300) @(negedge clk);
        check("t5.doneCount", 32'(doneCount - d0), 1);
        check("t5.busyAfter", 32'(busy), 0);

        // reset at cycle 100 aborts the scan
        for (int i = 0; i < NBINS; i++) hist[i] = CW'(i + 1);
        loadHist(6);
        d0 = doneCount;
        startScan(6, 0);
        repeat (99) @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        res = 1'b1;
        check("t6.busy", 32'(busy), 0);
        check("t6.rd_en", 32'(rd_en), 0);
        check("t6.wr_en", 32'(wr_en), 0);
        check("t6.rd_addr", 32'(rd_addr), 0);
        check("t6.wr_addr", 32'(wr_addr), 0);
        check("t6.peakCH", 32'(peakCH), 0);
        check("t6.peakCount", 32'(peakCount), 0);
        check("t6.peakPix", 32'(peakPix), 0);
        check("t6.peakValid", 32'(peakValid), 0);
        check("t6.peakDone", 32'(peakDone), 0);
        check("t6.bin98", 32'(mem[{4'd6, 8'd98}]), 0);
        check("t6.bin99", 32'(mem[{4'd6, 8'd99}]), 100);
        n = 0;
        for (int i = 99; i < NBINS; i++)
            if (mem[{4'd6, NB'(i)}] == CW'(i + 1)) n++;
        check("t6.kept", 32'(n), 157);
        repeat (5) @(negedge clk);
        check("t6.noDone", 32'(doneCount - d0), 0);
        pushExp(255, 256, 6, 1);
        startScan(6, 0);
        waitDone(1, lat);
        check("t6.latency", 32'(lat), 258);
        checkResult("t6");
        check("t6.cleared", 32'(nonZeroBins(6)), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
